// File: rtl/memctrl_pkg.sv
// memctrl_pkg: FSM encoding and shared constants for memory_controller
package memctrl_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, DONE = 2'd2} state_t;
  localparam int WAIT_CNT_W = 4;
  localparam logic [31:0] FAULT_READ_DATA = 32'h0;
endpackage

// File: rtl/ram_sp.sv
// ram_sp: single-port synchronous RAM with registered read (read-old-data)
module ram_sp #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32
) (
  input  logic              in_clk,
  input  logic              in_we,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [DATA_W-1:0] in_wdata,
  output logic [DATA_W-1:0] out_rdata
);
  logic [DATA_W-1:0] mem_q [2**ADDR_W];
  always_ff @(posedge in_clk) begin
    if (in_we) mem_q[in_addr] <= in_wdata;
    out_rdata <= mem_q[in_addr];
  end
endmodule

// File: rtl/memory_controller.sv
// memory_controller: MAR/MDR memory port with wait states, done strobe and sticky fault
// Optional upper-address range check enabled by MEMCTRL_RANGE_CHECK_EN.
module memory_controller
  import memctrl_pkg::*;
#(
  parameter int ADDR_W      = 9,
  parameter int DATA_W      = 32,
  parameter int WAIT_STATES = 2
) (
  input  logic              in_clk,
  input  logic              in_clr,
  input  logic [31:0]       in_address,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_read,
  input  logic              in_write,
  output logic [DATA_W-1:0] out_data,
  output logic              out_done,
  output logic              out_busy,
  output logic              out_fault
);
  state_t                  state_q;
  logic [WAIT_CNT_W-1:0]   cnt_q;
  logic [ADDR_W-1:0]       addr_q;
  logic [DATA_W-1:0]       wdata_q, data_q;
  logic                    write_q, range_err_q, range_err_d;
  logic                    busy_q, done_q, fault_q;
  logic                    idle, accept, conflict, commit, wr_now, err_now, ram_we;
  logic [ADDR_W-1:0]       ram_addr;
  logic [DATA_W-1:0]       ram_wdata, ram_rdata;
`ifdef MEMCTRL_RANGE_CHECK_EN
  assign range_err_d = |in_address[31:ADDR_W];
`else
  assign range_err_d = 1'b0 & (|in_address[31:ADDR_W]);
`endif
  assign idle     = state_q == IDLE;
  assign accept   = idle && (in_read ^ in_write);
  assign conflict = idle && in_read && in_write;
  assign commit   = in_clr && ((accept && WAIT_STATES == 0) ||
                               (state_q == WAIT && cnt_q == WAIT_CNT_W'(1)));
  // with zero wait states the commit edge is the acceptance edge, so use live inputs
  assign wr_now    = idle ? in_write : write_q;
  assign err_now   = idle ? range_err_d : range_err_q;
  assign ram_addr  = idle ? in_address[ADDR_W-1:0] : addr_q;
  assign ram_wdata = idle ? in_data : wdata_q;
  assign ram_we    = commit && wr_now && !err_now;
  ram_sp #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_ram (
    .in_clk   (in_clk),
    .in_we    (ram_we),
    .in_addr  (ram_addr),
    .in_wdata (ram_wdata),
    .out_rdata(ram_rdata)
  );
  // read data captured by the RAM at the commit edge is shown in DONE, then held
  assign out_data  = (state_q == DONE && !write_q)
                   ? (range_err_q ? DATA_W'(FAULT_READ_DATA) : ram_rdata) : data_q;
  assign out_done  = done_q;
  assign out_busy  = busy_q;
  assign out_fault = fault_q;
  always_ff @(posedge in_clk) begin
    if (!in_clr) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      done_q  <= commit;
      fault_q <= fault_q | conflict | (accept & range_err_d);
      if (state_q == DONE) data_q <= out_data;
      case (state_q)
        IDLE: if (accept) begin
          addr_q      <= in_address[ADDR_W-1:0];
          wdata_q     <= in_data;
          write_q     <= in_write;
          range_err_q <= range_err_d;
          cnt_q       <= WAIT_CNT_W'(WAIT_STATES);
          busy_q      <= 1'b1;
          state_q     <= commit ? DONE : WAIT;
        end
        WAIT: begin
          cnt_q <= cnt_q - 1'b1;
          if (commit) state_q <= DONE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_memory_controller.sv
// tb_memory_controller: scoreboard bench for memory_controller timing, data and fault behaviour
module tb_memory_controller;
  localparam int AW = 9;
  localparam int DW = 32;
  localparam int WS = 2;
`ifdef MEMCTRL_RANGE_CHECK_EN
  localparam logic RC = 1'b1;
`else
  localparam logic RC = 1'b0;
`endif
  typedef struct {logic chk; logic [31:0] data;} exp_t;
  logic        in_clk = 1'b0, in_clr = 1'b0, in_read = 1'b0, in_write = 1'b0;
  logic [31:0] in_address = '0, in_data = '0, out_data;
  logic        out_done, out_busy, out_fault;
  exp_t        sb[$];
  logic [31:0] model [int];
  logic [31:0] last_rd = '0;
  logic        rd_known = 1'b1;
  int          n_checks = 0, n_pass = 0, n_done = 0, n_req = 0;
  memory_controller #(.ADDR_W(AW), .DATA_W(DW), .WAIT_STATES(WS)) dut (
    .in_clk    (in_clk),
    .in_clr    (in_clr),
    .in_address(in_address),
    .in_data   (in_data),
    .in_read   (in_read),
    .in_write  (in_write),
    .out_data  (out_data),
    .out_done  (out_done),
    .out_busy  (out_busy),
    .out_fault (out_fault)
  );
  always #5 in_clk = ~in_clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask
  always @(negedge in_clk) begin
    if (out_done) begin
      exp_t e;
      n_done++;
      check("done_expected", 32'(sb.size() > 0), 32'd1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        if (e.chk) check("done_data", out_data, e.data);
      end
    end
  end
  task automatic push(input logic rd, input logic [31:0] addr, input logic [31:0] data);
    logic err;
    int   a;
    exp_t e;
    err = RC && (addr[31:AW] != '0);
    a   = int'(addr[AW-1:0]);
    if (rd) begin
      if (err) begin
        last_rd  = 32'h0;
        rd_known = 1'b1;
      end else if (model.exists(a)) begin
        last_rd  = model[a];
        rd_known = 1'b1;
      end else rd_known = 1'b0;
    end else if (!err) model[a] = data;
    e.chk  = rd_known;
    e.data = last_rd;
    sb.push_back(e);
    n_req++;
  endtask
  // drive at a negedge; checks busy/done over the whole transaction, optionally poking in_read while busy
  task automatic req(input logic rd, input logic [31:0] addr, input logic [31:0] data, input logic poke);
    in_read = rd; in_write = !rd; in_address = addr; in_data = data;
    push(rd, addr, data);
    @(negedge in_clk);
    in_read = 1'b0; in_write = 1'b0;
    for (int k = 1; k <= WS + 2; k++) begin
      check("busy", 32'(out_busy), 32'(k <= WS + 1));
      check("done", 32'(out_done), 32'(k == WS + 1));
      if (poke) in_read = (k == 1);
      if (k < WS + 2) @(negedge in_clk);
    end
  endtask
  initial begin
    repeat (2) @(negedge in_clk);
    check("rst_data", out_data, 32'h0);
    check("rst_done", 32'(out_done), 32'd0);
    check("rst_busy", 32'(out_busy), 32'd0);
    check("rst_fault", 32'(out_fault), 32'd0);
    in_clr = 1'b1;
    req(1'b1, 32'd5, 32'h0, 1'b0);
    req(1'b0, 32'd12, 32'hDEADBEEF, 1'b0);
    req(1'b1, 32'd12, 32'h0, 1'b0);
    req(1'b0, 32'd20, 32'h1234_5678, 1'b1);
    req(1'b1, 32'd20, 32'h0, 1'b1);
    check("fault_clean", 32'(out_fault), 32'd0);
    req(1'b0, 32'd7, 32'h0000_1111, 1'b0);
    in_write = 1'b1; in_address = 32'd7; in_data = 32'h0000_2222;
    @(negedge in_clk);
    in_write = 1'b0; in_clr = 1'b0;
    @(negedge in_clk);
    check("abort_data", out_data, 32'h0);
    check("abort_done", 32'(out_done), 32'd0);
    check("abort_busy", 32'(out_busy), 32'd0);
    check("abort_fault", 32'(out_fault), 32'd0);
    in_clr = 1'b1; last_rd = 32'h0; rd_known = 1'b1;
    repeat (WS + 2) @(negedge in_clk);
    req(1'b1, 32'd7, 32'h0, 1'b0);
    req(1'b0, 32'd5, 32'h5555_0005, 1'b0);
    req(1'b0, 32'h0000_0205, 32'h0BAD_0BAD, 1'b0);
    req(1'b1, 32'h0000_0205, 32'h0, 1'b0);
    check("range_fault", 32'(out_fault), 32'(RC));
    req(1'b1, 32'd5, 32'h0, 1'b0);
    in_read = 1'b1; in_write = 1'b1; in_address = 32'd12;
    @(negedge in_clk);
    in_read = 1'b0; in_write = 1'b0;
    check("conflict_busy", 32'(out_busy), 32'd0);
    check("conflict_fault", 32'(out_fault), 32'd1);
    repeat (WS + 2) begin
      @(negedge in_clk);
      check("conflict_no_done", 32'(out_done), 32'd0);
    end
    req(1'b1, 32'd12, 32'h0, 1'b0);
    check("fault_sticky", 32'(out_fault), 32'd1);
    in_clr = 1'b0;
    @(negedge in_clk);
    in_clr = 1'b1;
    check("fault_cleared", 32'(out_fault), 32'd0);
    check("clr_data", out_data, 32'h0);
    repeat (2) @(negedge in_clk);
    check("sb_empty", 32'(sb.size()), 32'd0);
    check("done_count", 32'(n_done), 32'(n_req));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/memory_controller.md
Name: memory_controller

Overview:
- Word-addressed memory subsystem directly downstream of the datapath's MAR/MDR.
- Accepts read/write requests addressed by the MAR value. Write data comes from the MDR.
- Returns read data to the MDR memory input (in_memory) after a configurable number of wait states.
- Raises a one-cycle done strobe, which the control unit uses to advance.

Parameters:
- ADDR_W, 9, word-address width; memory depth = 2**ADDR_W words.
- DATA_W, 32, data word width.
- WAIT_STATES, 2, extra cycles inserted between request acceptance and completion (0..15).

Ports:
- in_clk  input  1  clock, rising-edge.
- in_clr  input  1  synchronous, active-low reset. Sampled on the rising edge of in_clk; low clears state.
- in_address  input  32  word address, taken from MAR output.
- in_data  input  DATA_W  write data, taken from MDR output.
- in_read  input  1  read request, level-sampled.
- in_write  input  1  write request, level-sampled.
- out_data  output  DATA_W  read data, driven to MDR in_memory.
- out_done  output  1  one-cycle completion strobe.
- out_busy  output  1  high while a request is in flight.
- out_fault  output  1  sticky error flag.

Behaviour:
- Reset (in_clr low at an edge):
  - state <- IDLE; wait counter <- 0.
  - out_data, out_done, out_busy, out_fault <- 0.
  - Memory array contents are NOT cleared.
  - Reset mid-operation aborts the request. A write that has not reached its commit edge is never committed.
- FSM states: IDLE, WAIT, DONE.
- IDLE:
  - Request accepted at an edge where exactly one of in_read/in_write is high.
  - Address and write data are latched, and out_busy <- 1.
  - Next state is WAIT with the counter loaded to WAIT_STATES. If WAIT_STATES = 0, the next state is DONE directly.
- WAIT:
  - The counter decrements each cycle.
  - When the counter reaches 1, the next state is DONE.
- Commit edge (the edge entering DONE):
  - Write: array[addr] <- latched data.
  - Read: out_data <- array[addr].
  - out_done <- 1.
- DONE:
  - Lasts exactly one cycle with out_done = 1 and out_busy = 1.
  - Next edge: IDLE, out_done <- 0, out_busy <- 0.
- Latency: out_done is high in cycle N+WAIT_STATES+1, where the request was accepted at edge N. Back-to-back throughput is one request per WAIT_STATES+2 cycles.
- out_data holds its value until the next completed read. Writes do not change it.
- Requests presented while out_busy = 1 are ignored. There is no queueing, and the master must re-present the request.
- in_read and in_write both high in IDLE: no access, state stays IDLE, out_fault <- 1.
- Address width rule: only in_address[ADDR_W-1:0] indexes the array. Upper bits are handled per the optional feature below.
- out_fault is sticky and is cleared only by reset.

Optional Feature:
- Macro: MEMCTRL_RANGE_CHECK_EN.
- Defined:
  - in_address[31:ADDR_W] != 0 at acceptance -> the request still completes with normal timing.
  - Write: suppressed. Read: returns 32'h0.
  - out_fault <- 1.
- Undefined: upper address bits are ignored, the address wraps modulo 2**ADDR_W, and no fault is raised for range.

Decomposition:
- Package memctrl_pkg:
  - FSM state encoding (IDLE = 2'd0, WAIT = 2'd1, DONE = 2'd2).
  - Counter width constant WAIT_CNT_W = 4.
  - FAULT_READ_DATA = 32'h0.
- Sub-module ram_sp:
  - Single-port synchronous RAM, parameterised by ADDR_W/DATA_W.
  - Ports: in_clk, in_we, in_addr, in_wdata, out_rdata (registered read).
  - memory_controller owns the FSM, latches, counter and fault logic.

Test Plan:
- Reset then read address 5 (WAIT_STATES = 2; in_read high for one cycle at edge N) -> out_busy high from N+1; out_done high only in cycle N+3; out_data = 0 after power-up init.
- Write 32'hDEADBEEF to address 12, then read address 12 -> the read returns 32'hDEADBEEF; out_data is unchanged during the write's done cycle.
- Pulse in_read again while out_busy = 1 -> ignored; exactly one out_done pulse; the next request is accepted only after returning to IDLE.
- in_read and in_write both high in IDLE -> no out_done, out_fault = 1 and stays 1 until in_clr is low at an edge.
- Address 32'h0000_0205 with ADDR_W = 9:
  - Macro defined: out_fault = 1, read returns 0, write to word 5 suppressed.
  - Macro undefined: accesses word 5 and out_fault stays 0.
- Write to address 7 issued, then in_clr driven low in the WAIT cycle -> all outputs 0 next cycle; a later read of address 7 returns the old value.
